// File: rtl/treasure_tracker.sv
// Per-level treasure tracker: latches the placement map, counts it serially,
// reveals treasures on blasts and collects them when the player stands on them.
module treasure_tracker #(
   parameter int unsigned ROWS    = 12,
   parameter int unsigned COLS    = 12,
   parameter int unsigned POINTS  = 100,
   parameter int unsigned SCORE_W = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Load,
   input  logic [ROWS*COLS-1:0]   Treasure_Map_In,
   input  logic [ROWS*COLS-1:0]   Blast_Map,
   input  logic                   Player_Valid,
   input  logic [3:0]             Player_X,
   input  logic [3:0]             Player_Y,
   output logic [ROWS*COLS-1:0]   Treasure_Live,
   output logic [ROWS*COLS-1:0]   Treasure_Visible,
   output logic [7:0]             Treasures_Left,
   output logic                   Busy,
   output logic                   Collect_Pulse,
   output logic                   Level_Clear,
   output logic [SCORE_W-1:0]     Score
);

   localparam int unsigned CELLS = ROWS * COLS;
   localparam int unsigned IW    = $clog2(CELLS);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PLAY, S_DONE} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [IW-1:0]        r_idx;
   logic [CELLS-1:0]     r_live;
   logic [CELLS-1:0]     r_visible;
   logic [7:0]           r_count;
   logic                 r_collect;
   logic [SCORE_W-1:0]   r_score;

   logic [IW-1:0]        w_scan_pos;
   logic                 w_scan_bit;
   logic                 w_in_range;
   logic [IW-1:0]        w_cell_pos;
   logic [CELLS-1:0]     w_cell_mask;
   logic                 w_collect;
   logic [SCORE_W:0]     w_score_sum;
   logic [SCORE_W-1:0]   w_score_sat;

   // Row 0 / column 0 lives in the MSB, so both scan and player cells count down from the top.
   assign w_scan_pos  = IW'(CELLS - 1) - r_idx;
   assign w_scan_bit  = r_live[w_scan_pos];
   assign w_in_range  = (32'(Player_X) < COLS) && (32'(Player_Y) < ROWS);
   assign w_cell_pos  = IW'(CELLS - 1) - (IW'(Player_Y) * IW'(COLS) + IW'(Player_X));
   assign w_cell_mask = CELLS'(1) << w_cell_pos;
   assign w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(POINTS);
   assign w_score_sat = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_collect    = 1'b0;
      case (r_state)
         S_COUNT: begin
            if (r_idx == IW'(CELLS - 1))
               w_state_next = ((r_count != 8'd0) || w_scan_bit) ? S_PLAY : S_DONE;
         end
         S_PLAY: begin
            if (r_count == 8'd0) w_state_next = S_DONE;
            w_collect = Player_Valid && w_in_range && r_visible[w_cell_pos];
         end
         default: ;
      endcase
      // A reload overrides any collection or transition in the same cycle.
      if (Load) begin
         w_state_next = S_COUNT;
         w_collect    = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_idx     <= '0;
         r_live    <= '0;
         r_visible <= '0;
         r_count   <= '0;
         r_collect <= 1'b0;
         r_score   <= '0;
      end else if (Load) begin
         r_idx     <= '0;
         r_live    <= Treasure_Map_In;
         r_visible <= '0;
         r_count   <= '0;
         r_collect <= 1'b0;
      end else begin
         r_collect <= w_collect;
         case (r_state)
            S_COUNT: begin
               r_idx <= r_idx + 1'b1;
               if (w_scan_bit) r_count <= r_count + 8'd1;
            end
            S_PLAY: begin
               if (w_collect) begin
                  r_visible <= (r_visible | (Blast_Map & r_live)) & ~w_cell_mask;
                  r_live    <= r_live & ~w_cell_mask;
                  r_count   <= r_count - 8'd1;
                  r_score   <= w_score_sat;
               end else begin
                  r_visible <= r_visible | (Blast_Map & r_live);
               end
            end
            default: ;
         endcase
      end
   end

   assign Treasure_Live    = r_live;
   assign Treasure_Visible = r_visible;
   assign Treasures_Left   = r_count;
   assign Busy             = (r_state == S_COUNT);
   assign Collect_Pulse    = r_collect;
   assign Level_Clear      = (r_state == S_DONE);
   assign Score            = r_score;

endmodule
